// File: rtl/genetico_pkg.sv
// Shared parameters, field layout and FSM state type for the genetico configuration loader.
package genetico_pkg;
  localparam int N_LE     = 25;
  localparam int LE_W     = 15;
  localparam int N_OUT    = 8;
  localparam int OUT_W    = 6;
  localparam int N_SRC    = 33;
  localparam int LE_BITS  = N_LE * LE_W;
  localparam int CFG_BITS = LE_BITS + N_OUT * OUT_W;
  localparam int CNT_W    = $clog2(CFG_BITS);

  localparam int FUNC_LSB = 12;
  localparam int SELB_LSB = 6;
  localparam int SELA_LSB = 0;
  localparam int SEL_W    = 6;
  localparam int FUNC_W   = LE_W - FUNC_LSB;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_e;

  function automatic logic sel_illegal(input logic [SEL_W-1:0] sel);
    return int'(sel) >= N_SRC;
  endfunction
endpackage

// File: rtl/genetico_cfg_loader_if.sv
// Serial stream in, active chromosome configuration and status out.
interface genetico_cfg_loader_if;
  import genetico_pkg::*;

  logic                              start;
  logic                              ser_valid;
  logic                              ser_data;
  logic [N_LE-1:0][LE_W-1:0]         conf_les;
  logic [N_OUT-1:0][OUT_W-1:0]       conf_outs;
  logic                              cfg_valid;
  logic                              busy;
  logic                              done;
  logic                              err;

  modport master (
    output start, ser_valid, ser_data,
    input  conf_les, conf_outs, cfg_valid, busy, done, err
  );

  modport slave (
    input  start, ser_valid, ser_data,
    output conf_les, conf_outs, cfg_valid, busy, done, err
  );
endinterface

// File: rtl/cfg_range_check.sv
// Flags a frame whose LE input selects or output selects reach outside 0..N_SRC-1.
module cfg_range_check
  import genetico_pkg::*;
(
  input  logic [CFG_BITS-1:0] shadow_i,
  output logic                bad_o
);

  // Function codes are all legal; they are folded here only so every input bit has a reader.
  logic unused_func;

  always_comb begin
    bad_o       = 1'b0;
    unused_func = 1'b0;
    for (int i = 0; i < N_LE; i++) begin
      bad_o       = bad_o
                  | sel_illegal(shadow_i[i*LE_W + SELA_LSB +: SEL_W])
                  | sel_illegal(shadow_i[i*LE_W + SELB_LSB +: SEL_W]);
      unused_func = unused_func ^ (^shadow_i[i*LE_W + FUNC_LSB +: FUNC_W]);
    end
    for (int j = 0; j < N_OUT; j++) begin
      bad_o = bad_o | sel_illegal(shadow_i[LE_BITS + j*OUT_W +: OUT_W]);
    end
  end

endmodule

// File: rtl/genetico_cfg_loader.sv
// Shifts a chromosome frame into a shadow register and commits it atomically only if every select is in range.
module genetico_cfg_loader
  import genetico_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  genetico_cfg_loader_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_BITS - 1);

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              bit_cnt_q, bit_cnt_d;
  logic [CFG_BITS-1:0]           shadow_q;
  logic [N_LE-1:0][LE_W-1:0]     les_q;
  logic [N_OUT-1:0][OUT_W-1:0]   outs_q;
  logic                          cfg_valid_q;
  logic                          done_q, done_d;
  logic                          err_q, err_d;
  logic                          shift_en;
  logic                          bad;

  cfg_range_check u_check (
    .shadow_i (shadow_q),
    .bad_o    (bad)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_en  = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        // A restart wins over a coincident bit; the shadow keeps stale bits that the new frame overwrites.
        if (bus.start) begin
          bit_cnt_d = '0;
        end else if (bus.ser_valid) begin
          shift_en = 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = CHECK;
          else                       bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        done_d  = ~bad;
        err_d   = bad;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shadow_q    <= '0;
      les_q       <= '0;
      outs_q      <= '0;
      cfg_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      if (shift_en) shadow_q <= {bus.ser_data, shadow_q[CFG_BITS-1:1]};
      if (done_d) begin
        les_q       <= shadow_q[LE_BITS-1:0];
        outs_q      <= shadow_q[CFG_BITS-1:LE_BITS];
        cfg_valid_q <= 1'b1;
      end
    end
  end

  assign bus.conf_les  = les_q;
  assign bus.conf_outs = outs_q;
  assign bus.cfg_valid = cfg_valid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_genetico_cfg_loader.sv
// Bench for genetico_cfg_loader: frames built from field values, legality and committed image predicted per field.
module tb_genetico_cfg_loader;
  import genetico_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  genetico_cfg_loader_if bus();

  genetico_cfg_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int edge_cnt    = 0;
  int start_mark  = 0;
  int busy_low    = 0;

  int f_func [N_LE];
  int f_sa   [N_LE];
  int f_sb   [N_LE];
  int f_so   [N_OUT];

  logic [CFG_BITS-1:0] exp_active;
  bit                  exp_valid;

  function automatic logic [CFG_BITS-1:0] pack_frame();
    logic [CFG_BITS-1:0] fr;
    fr = '0;
    for (int k = 0; k < N_LE; k++)
      fr[k*LE_W +: LE_W] = {3'(f_func[k]), 6'(f_sb[k]), 6'(f_sa[k])};
    for (int j = 0; j < N_OUT; j++)
      fr[N_LE*LE_W + j*OUT_W +: OUT_W] = 6'(f_so[j]);
    return fr;
  endfunction

  function automatic bit frame_legal();
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < N_LE; k++)
      if (f_sa[k] >= N_SRC || f_sb[k] >= N_SRC) ok = 1'b0;
    for (int j = 0; j < N_OUT; j++)
      if (f_so[j] >= N_SRC) ok = 1'b0;
    return ok;
  endfunction

  function automatic void set_pattern();
    for (int k = 0; k < N_LE; k++) begin
      f_func[k] = k % 8;
      f_sa[k]   = k;
      f_sb[k]   = k + 1;
    end
    for (int j = 0; j < N_OUT; j++) f_so[j] = 8 + j;
  endfunction

  function automatic void set_random(input bit inject_bad);
    int idx;
    for (int k = 0; k < N_LE; k++) begin
      f_func[k] = int'($urandom_range(0, 7));
      f_sa[k]   = int'($urandom_range(0, N_SRC-1));
      f_sb[k]   = int'($urandom_range(0, N_SRC-1));
    end
    for (int j = 0; j < N_OUT; j++) f_so[j] = int'($urandom_range(0, N_SRC-1));
    if (inject_bad) begin
      idx = int'($urandom_range(0, 2*N_LE + N_OUT - 1));
      if (idx < N_LE)          f_sa[idx]          = int'($urandom_range(N_SRC, 63));
      else if (idx < 2*N_LE)   f_sb[idx-N_LE]     = int'($urandom_range(N_SRC, 63));
      else                     f_so[idx-2*N_LE]   = int'($urandom_range(N_SRC, 63));
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic drive_start();
    start_mark    = edge_cnt;
    bus.start     = 1'b1;
    bus.ser_valid = 1'b0;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic drive_bits(input logic [CFG_BITS-1:0] fr, input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      while (stall && ($urandom_range(0, 2) == 0)) begin
        bus.ser_valid = 1'b0;
        bus.ser_data  = 1'($urandom);
        tick();
        if (bus.busy !== 1'b1) busy_low++;
      end
      bus.ser_valid = 1'b1;
      bus.ser_data  = fr[i];
      tick();
      if (bus.busy !== 1'b1) busy_low++;
    end
    bus.ser_valid = 1'b0;
  endtask

  task automatic wait_result(output bit d, output bit e, output int edges);
    d = 1'b0; e = 1'b0; edges = -1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done === 1'b1 || bus.err === 1'b1) begin
        d = bus.done; e = bus.err; edges = edge_cnt - start_mark;
        return;
      end
    end
  endtask

  task automatic run_frame(input logic [CFG_BITS-1:0] fr, input bit stall,
                           output bit d, output bit e, output int edges);
    drive_start();
    drive_bits(fr, CFG_BITS, stall);
    wait_result(d, e, edges);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.ser_valid = 1'b0; bus.ser_data = 1'b0;
    tick(); tick();
    vectors++;
    if ({bus.cfg_valid, bus.busy, bus.done, bus.err} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_status: got %b expected 0000", {bus.cfg_valid, bus.busy, bus.done, bus.err});
    end
    vectors++;
    if ({bus.conf_outs, bus.conf_les} !== '0) begin
      miscompares++;
      $display("FAIL reset_conf: got %h expected 0", {bus.conf_outs, bus.conf_les});
    end
    rst_n = 1'b1;
    bus.ser_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.ser_valid = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.cfg_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%b cfg_valid=%b expected 0 0", bus.busy, bus.cfg_valid);
    end
    exp_active = '0;
    exp_valid  = 1'b0;
  endtask

  task automatic test_legal();
    logic [CFG_BITS-1:0] fr;
    bit d, e; int edges;
    set_pattern();
    fr = pack_frame();
    run_frame(fr, 1'b0, d, e, edges);
    exp_active = fr; exp_valid = 1'b1;
    vectors++;
    if (d !== 1'b1 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL legal_done: done=%b err=%b expected 1 0", d, e);
    end
    vectors++;
    if (edges != CFG_BITS + 2) begin
      miscompares++;
      $display("FAIL legal_latency: got %0d edges expected %0d", edges, CFG_BITS + 2);
    end
    vectors++;
    if (bus.conf_les[24] !== exp_active[24*LE_W +: LE_W]) begin
      miscompares++;
      $display("FAIL legal_le24: got %h expected %h", bus.conf_les[24], exp_active[24*LE_W +: LE_W]);
    end
    vectors++;
    if (bus.conf_outs[7] !== 6'd15) begin
      miscompares++;
      $display("FAIL legal_out7: got %0d expected 15", bus.conf_outs[7]);
    end
    vectors++;
    if ({bus.conf_outs, bus.conf_les} !== exp_active || bus.cfg_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL legal_image: cfg_valid=%b got %h expected %h", bus.cfg_valid, {bus.conf_outs, bus.conf_les}, exp_active);
    end
    tick();
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse_width: done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_illegal();
    bit d, e; int edges;
    set_pattern();
    f_so[3] = 40;
    run_frame(pack_frame(), 1'b0, d, e, edges);
    vectors++;
    if (d !== 1'b0 || e !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_err: done=%b err=%b expected 0 1", d, e);
    end
    vectors++;
    if ({bus.conf_outs, bus.conf_les} !== exp_active || bus.cfg_valid !== exp_valid) begin
      miscompares++;
      $display("FAIL illegal_keep: got %h expected %h", {bus.conf_outs, bus.conf_les}, exp_active);
    end
  endtask

  task automatic test_boundary();
    logic [CFG_BITS-1:0] fr;
    bit d, e; int edges;
    for (int k = 0; k < N_LE; k++) begin f_func[k] = 7; f_sa[k] = N_SRC-1; f_sb[k] = N_SRC-1; end
    for (int j = 0; j < N_OUT; j++) f_so[j] = N_SRC-1;
    fr = pack_frame();
    run_frame(fr, 1'b0, d, e, edges);
    exp_active = fr;
    vectors++;
    if (d !== 1'b1 || {bus.conf_outs, bus.conf_les} !== exp_active) begin
      miscompares++;
      $display("FAIL boundary_max_legal: done=%b got %h expected %h", d, {bus.conf_outs, bus.conf_les}, exp_active);
    end
    f_sb[0] = N_SRC;
    run_frame(pack_frame(), 1'b0, d, e, edges);
    vectors++;
    if (e !== 1'b1 || {bus.conf_outs, bus.conf_les} !== exp_active) begin
      miscompares++;
      $display("FAIL boundary_first_illegal: err=%b got %h expected %h", e, {bus.conf_outs, bus.conf_les}, exp_active);
    end
  endtask

  task automatic test_random_stalls();
    logic [CFG_BITS-1:0] fr;
    bit d, e, legal; int edges;
    for (int r = 0; r < 6; r++) begin
      set_random($urandom_range(0, 2) == 0);
      fr    = pack_frame();
      legal = frame_legal();
      run_frame(fr, 1'b1, d, e, edges);
      if (legal) exp_active = fr;
      vectors++;
      if (d !== legal || e !== !legal) begin
        miscompares++;
        $display("FAIL random_%0d_verdict: done=%b err=%b expected %b %b", r, d, e, legal, !legal);
      end
      vectors++;
      if ({bus.conf_outs, bus.conf_les} !== exp_active) begin
        miscompares++;
        $display("FAIL random_%0d_image: got %h expected %h", r, {bus.conf_outs, bus.conf_les}, exp_active);
      end
    end
  endtask

  task automatic test_restart();
    logic [CFG_BITS-1:0] fa, fb;
    bit d, e; int edges;
    set_random(1'b0); fa = pack_frame();
    set_random(1'b0); fb = pack_frame();
    drive_start();
    drive_bits(fa, 200, 1'b1);
    drive_start();
    drive_bits(fb, CFG_BITS, 1'b0);
    wait_result(d, e, edges);
    exp_active = fb;
    vectors++;
    if (d !== 1'b1 || edges != CFG_BITS + 2) begin
      miscompares++;
      $display("FAIL restart_done: done=%b edges=%0d expected 1 %0d", d, edges, CFG_BITS + 2);
    end
    vectors++;
    if ({bus.conf_outs, bus.conf_les} !== exp_active) begin
      miscompares++;
      $display("FAIL restart_image: got %h expected %h", {bus.conf_outs, bus.conf_les}, exp_active);
    end
  endtask

  task automatic test_reset_mid();
    logic [CFG_BITS-1:0] fr;
    bit d, e; int edges;
    set_random(1'b0); fr = pack_frame();
    drive_start();
    drive_bits(fr, 300, 1'b0);
    rst_n = 1'b0;
    #2;
    exp_active = '0; exp_valid = 1'b0;
    vectors++;
    if ({bus.cfg_valid, bus.busy, bus.done, bus.err} !== 4'b0 || {bus.conf_outs, bus.conf_les} !== exp_active) begin
      miscompares++;
      $display("FAIL reset_mid: status=%b conf=%h expected 0000 0", {bus.cfg_valid, bus.busy, bus.done, bus.err}, {bus.conf_outs, bus.conf_les});
    end
    tick();
    rst_n = 1'b1;
    tick();
    set_random(1'b0); fr = pack_frame();
    run_frame(fr, 1'b1, d, e, edges);
    exp_active = fr; exp_valid = 1'b1;
    vectors++;
    if (d !== 1'b1 || bus.cfg_valid !== 1'b1 || {bus.conf_outs, bus.conf_les} !== exp_active) begin
      miscompares++;
      $display("FAIL after_reset_frame: done=%b cfg_valid=%b got %h expected %h", d, bus.cfg_valid, {bus.conf_outs, bus.conf_les}, exp_active);
    end
  endtask

  task automatic test_back_to_back();
    logic [CFG_BITS-1:0] fa, fb;
    bit d, e; int edges;
    set_random(1'b0); fa = pack_frame();
    set_random(1'b0); fb = pack_frame();
    run_frame(fa, 1'b0, d, e, edges);
    vectors++;
    if (d !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_first: done=%b busy=%b expected 1 0", d, bus.busy);
    end
    busy_low = 0;
    drive_start();
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_start_in_done: busy=%b expected 1", bus.busy);
    end
    drive_bits(fb, CFG_BITS, 1'b0);
    wait_result(d, e, edges);
    exp_active = fb;
    vectors++;
    if (d !== 1'b1 || edges != CFG_BITS + 2 || busy_low != 0) begin
      miscompares++;
      $display("FAIL b2b_second: done=%b edges=%0d busy_low=%0d expected 1 %0d 0", d, edges, busy_low, CFG_BITS + 2);
    end
    vectors++;
    if ({bus.conf_outs, bus.conf_les} !== exp_active) begin
      miscompares++;
      $display("FAIL b2b_image: got %h expected %h", {bus.conf_outs, bus.conf_les}, exp_active);
    end
  endtask

  initial begin
    test_reset();
    test_legal();
    test_illegal();
    test_boundary();
    test_random_stalls();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
